// File: rtl/reg_file_mp_if.sv
// ---------------------------------------------------------------------------
// reg_file_mp_if -- bus bundle for the reg_file_mp register file.
//
// Parameters:
//   DATA_W  register data width in bits
//   ADDR_W  address width (DEPTH = 2**ADDR_W)
//
// Signals (direction seen from the register file, i.e. the slave modport):
//   addr_a   in   ADDR_W  read port A address
//   addr_b   in   ADDR_W  read port B address
//   data_a   out  DATA_W  read port A data (combinational)
//   data_b   out  DATA_W  read port B data (combinational)
//   addr_d   in   ADDR_W  write address
//   data_d   in   DATA_W  write data
//   regwen   in   1       write enable
//   clr_req  in   1       single-cycle request to zero all entries
//   busy     out  1       registered; high while a clear sweep runs
// ---------------------------------------------------------------------------
interface reg_file_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) ();

    logic [ADDR_W-1:0] addr_a;
    logic [ADDR_W-1:0] addr_b;
    logic [DATA_W-1:0] data_a;
    logic [DATA_W-1:0] data_b;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] data_d;
    logic              regwen;
    logic              clr_req;
    logic              busy;

    // Requester side: drives addresses, write data and control.
    modport master (
        output addr_a, addr_b, addr_d, data_d, regwen, clr_req,
        input  data_a, data_b, busy
    );

    // Register-file side.
    modport slave (
        input  addr_a, addr_b, addr_d, data_d, regwen, clr_req,
        output data_a, data_b, busy
    );

endinterface

// File: rtl/reg_file_mp.sv
// ---------------------------------------------------------------------------
// reg_file_mp -- two-read / one-write register file with a sequential
// clear sweep.
//
// Reads are combinational. A clear (clr_req, or reset) walks every entry
// one per cycle writing zero; while the sweep runs busy is high, both read
// ports return zero and writes are dropped. Optionally entry 0 is
// hardwired to zero (ZERO_REG=1).
//
// Parameters:
//   DATA_W    data width (default 32)
//   ADDR_W    address width, DEPTH = 2**ADDR_W (default 5)
//   ZERO_REG  1: entry 0 reads zero and ignores writes (default 1)
//
// Ports:
//   clk    in  clock, all state updates on the rising edge
//   rst_n  in  synchronous active-low reset; starts a full clear sweep
//   bus    reg_file_mp_if.slave (addr_a/addr_b/data_a/data_b read ports,
//          addr_d/data_d/regwen write port, clr_req, busy)
//
// Build option:
//   REG_FILE_MP_BYPASS_EN  when defined, a write issued in IDLE is forwarded
//                          combinationally to any read port addressing the
//                          same entry (never for entry 0 when ZERO_REG=1).
// ---------------------------------------------------------------------------
module reg_file_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    reg_file_mp_if.slave bus
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        S_IDLE,
        S_CLEAR
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_clr_idx;
    logic [ADDR_W-1:0] w_clr_idx_nxt;
    logic              r_busy;
    logic              w_busy_nxt;

    // Single write port into the array, shared by user writes and the sweep.
    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [DATA_W-1:0] w_wdata;

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic [DATA_W-1:0] w_data_a;
    logic [DATA_W-1:0] w_data_b;

    logic w_zero_a;
    logic w_zero_b;
    logic w_zero_d;

    assign w_zero_a = (ZERO_REG != 0) && (bus.addr_a == '0);
    assign w_zero_b = (ZERO_REG != 0) && (bus.addr_b == '0);
    assign w_zero_d = (ZERO_REG != 0) && (bus.addr_d == '0);

    // -----------------------------------------------------------------------
    // FSM: state register
    // Reset lands directly in CLEAR at index 0, so releasing reset (or
    // pulsing it mid-sweep) always yields a complete DEPTH-cycle sweep.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_CLEAR;
            r_clr_idx <= '0;
            r_busy    <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_idx <= w_clr_idx_nxt;
            r_busy    <= w_busy_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // busy is registered, so its next value is decided here together with
    // the state; it is high exactly while the FSM sits in CLEAR.
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_idx_nxt = r_clr_idx;
        w_busy_nxt    = r_busy;
        unique case (r_state)
            S_IDLE: begin
                if (bus.clr_req) begin
                    w_state_nxt   = S_CLEAR;
                    w_clr_idx_nxt = '0;
                    w_busy_nxt    = 1'b1;
                end
            end
            S_CLEAR: begin
                // clr_req is ignored here; the running sweep is not restarted.
                if (r_clr_idx == LAST_IDX) begin
                    // Last entry written this cycle; index is left as-is
                    // (no wrap) and only reloaded on the next clear.
                    w_state_nxt = S_IDLE;
                    w_busy_nxt  = 1'b0;
                end else begin
                    w_clr_idx_nxt = r_clr_idx + ADDR_W'(1);
                end
            end
            default: begin
                w_state_nxt   = S_CLEAR;
                w_clr_idx_nxt = '0;
                w_busy_nxt    = 1'b1;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: output logic -- selects who owns the array write port.
    // In IDLE a clear request wins over a simultaneous write, and writes to
    // a hardwired-zero entry 0 are dropped. In CLEAR the sweep owns the port
    // and user writes are lost.
    // -----------------------------------------------------------------------
    always_comb begin
        w_we    = 1'b0;
        w_waddr = bus.addr_d;
        w_wdata = bus.data_d;
        unique case (r_state)
            S_IDLE: begin
                w_we    = bus.regwen && !bus.clr_req && !w_zero_d;
                w_waddr = bus.addr_d;
                w_wdata = bus.data_d;
            end
            S_CLEAR: begin
                w_we    = 1'b1;
                w_waddr = r_clr_idx;
                w_wdata = '0;
            end
            default: begin
                w_we = 1'b0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Storage array. No reset on the data itself: the sweep that follows
    // reset zeroes every entry, and reads are forced to zero until it ends.
    // Gating on rst_n drops any write presented in a reset cycle.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst_n && w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    // -----------------------------------------------------------------------
    // Read ports. Override order matters: forwarding first, then the
    // hardwired zero entry (so entry 0 is never forwarded), then busy.
    // -----------------------------------------------------------------------
    always_comb begin
        w_data_a = r_mem[bus.addr_a];
`ifdef REG_FILE_MP_BYPASS_EN
        if ((r_state == S_IDLE) && bus.regwen && (bus.addr_d == bus.addr_a)) begin
            w_data_a = bus.data_d;
        end
`endif
        if (w_zero_a) begin
            w_data_a = '0;
        end
        if (r_busy) begin
            w_data_a = '0;
        end
    end

    always_comb begin
        w_data_b = r_mem[bus.addr_b];
`ifdef REG_FILE_MP_BYPASS_EN
        if ((r_state == S_IDLE) && bus.regwen && (bus.addr_d == bus.addr_b)) begin
            w_data_b = bus.data_d;
        end
`endif
        if (w_zero_b) begin
            w_data_b = '0;
        end
        if (r_busy) begin
            w_data_b = '0;
        end
    end

    assign bus.data_a = w_data_a;
    assign bus.data_b = w_data_b;
    assign bus.busy   = r_busy;

endmodule

// File: doc/reg_file_mp.md
REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the register data width in bits.
REQ-002 Parameter ADDR_W, default 5, SHALL set the address width; depth DEPTH = 2^ADDR_W entries.
REQ-003 Parameter ZERO_REG, default 1, SHALL make entry 0 hardwired to zero when 1, or an ordinary entry when 0.
REQ-004 Clock and reset SHALL be one clock, with a synchronous, active-low reset.
REQ-005 clk  input  1  clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  synchronous active-low reset.
REQ-007 addr_a  input  ADDR_W  read port A address.
REQ-008 addr_b  input  ADDR_W  read port B address.
REQ-009 data_a  output  DATA_W  read port A data.
REQ-010 data_b  output  DATA_W  read port B data.
REQ-011 addr_d  input  ADDR_W  write address.
REQ-012 data_d  input  DATA_W  write data.
REQ-013 regwen  input  1  write enable.
REQ-014 clr_req  input  1  single-cycle request to zero all entries.
REQ-015 busy  output  1  registered; high while a clear sweep is in progress.

Function
REQ-016 Reads SHALL be combinational: data_a = entry[addr_a] and data_b = entry[addr_b], with no clock latency.
REQ-017 If ZERO_REG=1, a read of address 0 SHALL return 0, and a write to address 0 SHALL be discarded.
REQ-018 While busy=1, data_a and data_b SHALL both read 0, regardless of address.
REQ-019 In state IDLE, regwen=1 SHALL write data_d into entry[addr_d] at the rising edge; the new value becomes visible on the read ports in the following cycle.
REQ-020 The FSM SHALL have two states, IDLE and CLEAR, plus a clear counter clr_idx of ADDR_W bits.
REQ-021 IDLE -> CLEAR SHALL occur on clr_req=1; clr_idx is loaded with 0 and busy is set to 1 on the same edge.
REQ-022 In CLEAR, each cycle SHALL write 0 to entry[clr_idx] and increment clr_idx.
REQ-023 When clr_idx = DEPTH-1 is written, the FSM SHALL go CLEAR -> IDLE and busy -> 0 on that edge; a sweep lasts exactly DEPTH cycles.
REQ-024 In CLEAR, regwen SHALL be ignored and the write is lost (no queuing).
REQ-025 clr_req while in CLEAR SHALL be ignored; the sweep is not restarted.
REQ-026 clr_req=1 and regwen=1 in the same IDLE cycle: the clear SHALL win and the write is discarded.
REQ-027 clr_idx SHALL not wrap; it is only meaningful in CLEAR.
REQ-028 Out-of-range conditions are impossible by construction; every ADDR_W value is a valid entry.

Reset
REQ-029 rst_n=0 at a rising edge SHALL force state CLEAR, clr_idx=0, and busy=1.
REQ-030 After rst_n returns high, the sweep SHALL run DEPTH cycles, then busy=0; all entries are then 0.
REQ-031 Reset asserted mid-sweep SHALL restart the sweep from index 0.
REQ-032 Reset asserted mid-write SHALL discard the write.
REQ-033 During reset and the sweep, data_a and data_b SHALL read 0.

Configuration
REQ-034 Macro REG_FILE_MP_BYPASS_EN defined: in IDLE, when regwen=1 and addr_d equals addr_a (or addr_b), that read port SHALL return data_d combinationally in the same cycle.
REQ-035 With REG_FILE_MP_BYPASS_EN defined and ZERO_REG=1, address 0 SHALL never be bypassed.
REQ-036 Macro REG_FILE_MP_BYPASS_EN undefined: there SHALL be no forwarding; read ports show only stored contents.

Verification
REQ-037 Power-up: rst_n=0 for 2 cycles, then 1 -> busy=1 for exactly 32 cycles (defaults), then 0; reading any address returns 0x00000000.
REQ-038 Write/read: regwen=1, addr_d=5, data_d=0xDEADBEEF; next cycle addr_a=5 -> data_a=0xDEADBEEF; regwen=1, addr_d=0, data_d=0x1234 then addr_b=0 -> data_b=0.
REQ-039 Bypass: REG_FILE_MP_BYPASS_EN defined, entry 7=0x11, regwen=1, addr_d=7, data_d=0x22, addr_a=7 -> data_a=0x22 in the same cycle; macro undefined -> data_a=0x11.
REQ-040 Clear collision: entry 3=0xAA, clr_req=1 with regwen=1, addr_d=9, data_d=0x55 -> busy high 32 cycles; afterwards entries 3 and 9 read 0; regwen=1 on sweep cycle 10 is also lost.
REQ-041 Mid-sweep reset: clr_req, then rst_n=0 on sweep cycle 20 for 1 cycle -> busy stays high for 32 further cycles after release; all entries read 0.
REQ-042 Parameters: DATA_W=16, ADDR_W=3, ZERO_REG=0 -> sweep takes 8 cycles; write 0xBEEF to address 0 reads back 0xBEEF.
